// File: rtl/da_seq_ctrl_if.sv
// da_seq_ctrl_if: sample handshake, coefficient preload and DA datapath control bundle.
// master = sequencer side, slave = sample source / datapath side.
interface da_seq_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int NPART  = 4,
    parameter int ROM_AW = 4
);
    localparam int AW = $clog2(NPART << ROM_AW);
    localparam int BW = $clog2(DATA_W);
    logic          cload, coef_valid, valid_in, ready_in;
    logic [AW-1:0] load_addr;
    logic          load_done, cen_n, wen_n, load_zreg, shift_en;
    logic [BW-1:0] bit_sel;
    logic          acc_en, acc_load, acc_sub, valid_out, busy;
    modport master (
        input  cload, coef_valid, valid_in,
        output ready_in, load_addr, load_done, cen_n, wen_n, load_zreg, shift_en,
               bit_sel, acc_en, acc_load, acc_sub, valid_out, busy
    );
    modport slave (
        output cload, coef_valid, valid_in,
        input  ready_in, load_addr, load_done, cen_n, wen_n, load_zreg, shift_en,
               bit_sel, acc_en, acc_load, acc_sub, valid_out, busy
    );
endinterface

// File: rtl/da_seq_ctrl.sv
// da_seq_ctrl: DA FIR sequencer (ROM preload, bit-serial iteration, accumulator control).
// Optional DA_SEQ_OVERLAP_EN: accept the next sample in the last bit cycle.
module da_seq_ctrl #(
    parameter int DATA_W = 16,
    parameter int NPART  = 4,
    parameter int ROM_AW = 4
) (
    input logic           clk,
    input logic           resetn,
    da_seq_ctrl_if.master bus
);
    localparam int TS = $clog2(NPART);
    localparam int LAT = 1 + TS;
    localparam int NWORDS = NPART << ROM_AW;
    localparam int AW = $clog2(NWORDS);
    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
    localparam logic [AW-1:0] ADDR_MAX = AW'(NWORDS - 1);

    typedef enum logic [1:0] {IDLE, LATCH, BITS, DRAIN} state_t;
    state_t state, state_n;
    logic [AW-1:0] addr, load_addr;
    logic [BW-1:0] bit_sel, bit_sel_n;
    logic [LAT-1:0] pe, pl, ps;
    logic load_done, cen_n, wen_n, load_zreg, shift_en, valid_out, busy;
    logic in_bits, last_bit, accept, wr, vo_n;

    assign in_bits = state == BITS;
    assign last_bit = in_bits && bit_sel == LAST;
`ifdef DA_SEQ_OVERLAP_EN
    assign bus.ready_in = (state == IDLE || last_bit) && load_done && !bus.cload;
`else
    assign bus.ready_in = state == IDLE && load_done && !bus.cload;
`endif
    assign accept = bus.valid_in && bus.ready_in;
    assign wr = state == IDLE && bus.cload && bus.coef_valid && !load_done;
    assign vo_n = pe[LAT-1] && ps[LAT-1];

    always_comb begin
        state_n = state;
        bit_sel_n = bit_sel;
        case (state)
            IDLE:  state_n = accept ? LATCH : IDLE;
            LATCH: begin
                state_n = BITS;
                bit_sel_n = '0;
            end
            BITS:  begin
                state_n = !last_bit ? BITS : accept ? LATCH : DRAIN;
                bit_sel_n = last_bit ? bit_sel : bit_sel + 1'b1;
            end
            DRAIN: state_n = valid_out ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    // load_addr lags the counter so it names the word written while wen_n is low
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            addr <= '0;
            load_addr <= '0;
            bit_sel <= '0;
            load_done <= 1'b0;
            cen_n <= 1'b1;
            wen_n <= 1'b1;
            load_zreg <= 1'b0;
            shift_en <= 1'b0;
            pe <= '0;
            pl <= '0;
            ps <= '0;
            valid_out <= 1'b0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            addr <= addr + AW'(wr);
            load_addr <= addr;
            load_done <= load_done || (wr && addr == ADDR_MAX);
            bit_sel <= bit_sel_n;
            cen_n <= !(wr || state_n == BITS);
            wen_n <= !wr;
            load_zreg <= state_n == LATCH;
            shift_en <= state_n == BITS && bit_sel_n != LAST;
            pe <= {pe[LAT-2:0], in_bits};
            pl <= {pl[LAT-2:0], in_bits && bit_sel == '0};
            ps <= {ps[LAT-2:0], last_bit};
            valid_out <= vo_n;
            busy <= state_n != IDLE || |{pe[LAT-2:0], in_bits} || vo_n;
        end
    end

    assign bus.load_addr = load_addr;
    assign bus.load_done = load_done;
    assign bus.cen_n = cen_n;
    assign bus.wen_n = wen_n;
    assign bus.load_zreg = load_zreg;
    assign bus.shift_en = shift_en;
    assign bus.bit_sel = bit_sel;
    assign bus.acc_en = pe[LAT-1];
    assign bus.acc_load = pl[LAT-1];
    assign bus.acc_sub = ps[LAT-1];
    assign bus.valid_out = valid_out;
    assign bus.busy = busy;
endmodule

// File: doc/da_seq_ctrl.md
# da_seq_ctrl

Parametrised sequencer for the distributed-arithmetic FIR datapath. It streams precomputed partial-sum words into the partitioned ROM and accepts input samples over a valid/ready handshake. For each sample it drives DATA_W bit-serial ROM-read/accumulate iterations, including sign-bit subtraction for two's-complement samples, then pulses `valid_out`. It sits between the sample source and the DA datapath (zreg shift register, ROM partitions, adder tree, accumulator), with the tree depth derived from the partition count.

## Interface
- DATA_W, 16, sample width; number of bit-serial iterations per sample (≥2)
- NPART, 4, ROM partitions (power of 2, ≥2); adder-tree stages TS = clog2(NPART)
- ROM_AW, 4, address bits per partition; preload length NWORDS = NPART·2^ROM_AW
- LAT (localparam), 1 + TS, cycles from ROM read to accumulator input
- Reset: `resetn` is synchronous, active-low; clock is `clk`.
- clk  in  1  clock, all state updates on rising edge
- resetn  in  1  synchronous active-low reset
- cload  in  1  coefficient-load mode request
- coef_valid  in  1  preload word present this cycle
- valid_in  in  1  sample present
- ready_in  out  1  sample accepted when valid_in & ready_in
- load_addr  out  clog2(NWORDS)  preload write address
- load_done  out  1  all NWORDS written; sticky until reset
- cen_n, wen_n  out  1 each  ROM chip/write enable, active-low
- load_zreg  out  1  capture sample into zreg
- shift_en  out  1  advance zreg one bit
- bit_sel  out  clog2(DATA_W)  current bit index
- acc_en  out  1  accumulator updates this cycle
- acc_load  out  1  with acc_en: load instead of add (first bit)
- acc_sub  out  1  with acc_en: subtract (MSB bit)
- valid_out  out  1  one-cycle pulse; accumulator holds the result
- busy  out  1  state ≠ IDLE or pipeline non-empty

## Operation
- States: IDLE, LATCH, BITS, DRAIN. All outputs are registered except `ready_in`.
- Reset: state IDLE. `load_addr`, `bit_sel` and `load_done` clear to 0. All strobes clear to 0. `cen_n` and `wen_n` go to 1. The LAT-deep control pipeline flushes. ROM contents are not touched, but `load_done` must be re-earned by a new preload.
- IDLE, `cload`=1:
  - Each cycle with `coef_valid`=1 and `load_done`=0: `cen_n`=`wen_n`=0 at `load_addr`, then the address increments.
  - The write at NWORDS−1 sets `load_done`, and the address wraps to 0.
  - Further `coef_valid` cycles keep `wen_n`=1.
- `ready_in` = IDLE & `load_done` & ~`cload`. `cload` has priority over `valid_in`.
- A `cload` request that arrives outside IDLE is ignored until IDLE is reached.
- Accept → LATCH. LATCH asserts `load_zreg`=1 for one cycle, then goes to BITS.
- BITS, k = 0..DATA_W−1, one cycle each:
  - `cen_n`=0, `wen_n`=1, `bit_sel`=k.
  - `shift_en`=1 for k < DATA_W−1.
  - k enters the control pipeline tagged load (k=0) and sub (k=DATA_W−1).
- After the last bit: BITS → DRAIN. DRAIN lasts until `valid_out` is emitted, then → IDLE.
- Pipeline: `acc_en`/`acc_load`/`acc_sub` appear LAT cycles after the matching BITS cycle. `valid_out` follows the `acc_sub` cycle by 1 cycle.

## Timing
- Accept at cycle T:
  - `load_zreg` at T+1.
  - BITS at T+2 .. T+1+DATA_W.
  - `acc_en` at T+2+LAT .. T+1+DATA_W+LAT.
  - `valid_out` at T+2+DATA_W+LAT. With defaults this is T+21.
- Without overlap, the next accept is at the earliest T+3+DATA_W+LAT.
- Reset asserted mid-sample: on the next edge all strobes go low and no `valid_out` is produced for the aborted sample.

## Configuration
- DA_SEQ_OVERLAP_EN defined:
  - `ready_in` is also high in the last BITS cycle (when `load_done` & ~`cload`).
  - An accept there goes directly to LATCH, skipping DRAIN. The pipeline drains concurrently.
  - Sustained throughput is one sample per DATA_W+1 cycles.
  - The next `acc_load` lands exactly one cycle after the previous `valid_out`.
- Undefined: `ready_in` is high only in IDLE, per the Timing section.

## Test plan
- Reset, then 64 `coef_valid` beats with `cload`=1 (defaults) → `wen_n`=0 on addresses 0..63; `load_done` rises after beat 64; `ready_in` stays 0 throughout; a 65th beat keeps `wen_n`=1.
- `valid_in` before preload is complete → `ready_in`=0, no `load_zreg`; after preload, accept at T → `load_zreg` at T+1, `acc_load` at T+5, `acc_sub` at T+20, `valid_out` at T+21 only.
- Back-to-back `valid_in`:
  - Overlap undefined → accepts 22 cycles apart.
  - DA_SEQ_OVERLAP_EN defined → accepts 17 cycles apart; `acc_load` of sample 2 one cycle after `valid_out` of sample 1.
- `cload` and `valid_in` both high in IDLE → no accept; the preload write proceeds if `load_done`=0.
- `resetn` low at BITS k=7 → next cycle all strobes 0, `cen_n`=`wen_n`=1, `load_done`=0, no `valid_out` in the following 30 cycles.
- DATA_W=8, NPART=8 instance → LAT=4; `valid_out` at T+14.
